// File: rtl/quadrature_mixer.sv
// Real-input downconversion mixer: I = adc*cos, Q = -adc*sin, with gain, rounding,
// saturation and sticky overflow. All datapath registers advance on sample_clk_ce.
module quadrature_mixer #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned ADC_DELAY  = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  sample_clk_ce,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  adc_offset_binary,
  input  logic [DATA_WIDTH-1:0] sinewave,
  input  logic [DATA_WIDTH-1:0] cosinewave,
  input  logic [2:0]            gain_shift,
  input  logic                  clear_ovf,
  output logic [OUT_WIDTH-1:0]  i_out,
  output logic [OUT_WIDTH-1:0]  q_out,
  output logic                  out_valid,
  output logic                  ovf_i,
  output logic                  ovf_q
);

  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned PW     = 2 * DATA_WIDTH;
  localparam int unsigned SW     = PW + 8;
  localparam int unsigned RND_SH = PW - 1 - OUT_WIDTH;
  localparam int unsigned PRIME  = ADC_DELAY + 3;
  localparam int unsigned CW     = $clog2(PRIME + 1);
  localparam logic signed [SW-1:0] RND = SW'(64'd1 << (RND_SH - 1));

  logic [DW-1:0]          adc_c_q, adc_c_d;
  logic [DW-1:0]          adc_al;
  logic signed [PW:0]     p_i_q, p_i_d, p_q_q, p_q_d;
  logic [OUT_WIDTH-1:0]   i_q, i_d, q_q, q_d;
  logic                   out_valid_q, out_valid_d;
  logic                   ovf_i_q, ovf_i_d, ovf_q_q, ovf_q_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic signed [PW-1:0]   adc_ext, sin_ext, cos_ext;
  logic signed [PW-1:0]   prod_i_c, prod_q_c;
  logic [OUT_WIDTH:0]     sc_i, sc_q;

  // Shift, round half up on bits [PW-2:PW-1-OUT_WIDTH], saturate; MSB of result is the saturation flag.
  function automatic logic [OUT_WIDTH:0] scale(input logic signed [PW:0] p, input logic [2:0] sh);
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] t;
    logic signed [SW-1:0] r;
    logic                 fits;
    s = {{(SW-PW-1){p[PW]}}, p};
    s = s <<< sh;
    t = s + RND;
    r = t >>> RND_SH;
    fits = (&r[SW-1:OUT_WIDTH-1]) | ~(|r[SW-1:OUT_WIDTH-1]);
    if (fits) begin
      scale = {1'b0, r[OUT_WIDTH-1:0]};
    end else if (r[SW-1]) begin
      scale = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      scale = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  endfunction

  // Alignment delay between capture and multiply, matching NCO latency.
  if (ADC_DELAY == 0) begin : g_nodly
    assign adc_al = adc_c_q;
  end else begin : g_dly
    logic [DW-1:0] dly_q [ADC_DELAY];
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        for (int k = 0; k < int'(ADC_DELAY); k++) dly_q[k] <= '0;
      end else if (sample_clk_ce) begin
        dly_q[0] <= adc_c_q;
        for (int k = 1; k < int'(ADC_DELAY); k++) dly_q[k] <= dly_q[k-1];
      end
    end
    assign adc_al = dly_q[ADC_DELAY-1];
  end

  assign adc_ext  = PW'($signed(adc_al));
  assign sin_ext  = PW'($signed(sinewave));
  assign cos_ext  = PW'($signed(cosinewave));
  assign prod_i_c = adc_ext * cos_ext;
  assign prod_q_c = adc_ext * sin_ext;
  assign sc_i     = scale(p_i_q, gain_shift);
  assign sc_q     = scale(p_q_q, gain_shift);
  assign cnt_inc  = (cnt_q == CW'(PRIME)) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    adc_c_d     = adc_c_q;
    p_i_d       = p_i_q;
    p_q_d       = p_q_q;
    i_d         = i_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    if (sample_clk_ce) begin
      adc_c_d     = {adc_data[DW-1] ^ adc_offset_binary, adc_data[DW-2:0]};
      p_i_d       = {prod_i_c[PW-1], prod_i_c};
      // Negate after widening so the most negative product cannot wrap.
      p_q_d       = -{prod_q_c[PW-1], prod_q_c};
      i_d         = sc_i[OUT_WIDTH-1:0];
      q_d         = sc_q[OUT_WIDTH-1:0];
      cnt_d       = cnt_inc;
      out_valid_d = (cnt_inc == CW'(PRIME));
    end
    // A saturation registered this cycle wins over a simultaneous clear.
    ovf_i_d = (sample_clk_ce & sc_i[OUT_WIDTH]) | (ovf_i_q & ~clear_ovf);
    ovf_q_d = (sample_clk_ce & sc_q[OUT_WIDTH]) | (ovf_q_q & ~clear_ovf);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      adc_c_q     <= '0;
      p_i_q       <= '0;
      p_q_q       <= '0;
      i_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_i_q     <= 1'b0;
      ovf_q_q     <= 1'b0;
    end else begin
      adc_c_q     <= adc_c_d;
      p_i_q       <= p_i_d;
      p_q_q       <= p_q_d;
      i_q         <= i_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      ovf_i_q     <= ovf_i_d;
      ovf_q_q     <= ovf_q_d;
    end
  end

  assign i_out     = i_q;
  assign q_out     = q_q;
  assign out_valid = out_valid_q;
  assign ovf_i     = ovf_i_q;
  assign ovf_q     = ovf_q_q;

endmodule

// File: tb/tb_quadrature_mixer.sv
// Directed bench for quadrature_mixer: one instance with ADC_DELAY=0, one with ADC_DELAY=2.
module tb_quadrature_mixer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n, ce, obin, clear_ovf;
  logic [11:0] adc_data, sinw, cosw;
  logic [2:0]  gain;
  logic signed [15:0] i0, q0, i2, q2;
  logic v0, v2, oi0, oq0, oi2, oq2;

  int n_chk = 0;
  int n_pass = 0;

  quadrature_mixer #(.DATA_WIDTH(12), .OUT_WIDTH(16), .ADC_DELAY(0)) dut0 (
    .clk(clk), .arst_n(arst_n), .sample_clk_ce(ce), .adc_data(adc_data),
    .adc_offset_binary(obin), .sinewave(sinw), .cosinewave(cosw), .gain_shift(gain),
    .clear_ovf(clear_ovf), .i_out(i0), .q_out(q0), .out_valid(v0), .ovf_i(oi0), .ovf_q(oq0));

  quadrature_mixer #(.DATA_WIDTH(12), .OUT_WIDTH(16), .ADC_DELAY(2)) dut2 (
    .clk(clk), .arst_n(arst_n), .sample_clk_ce(ce), .adc_data(adc_data),
    .adc_offset_binary(obin), .sinewave(sinw), .cosinewave(cosw), .gain_shift(gain),
    .clear_ovf(clear_ovf), .i_out(i2), .q_out(q2), .out_valid(v2), .ovf_i(oi2), .ovf_q(oq2));

  typedef struct {
    int adc; bit ob; int sn; int cs; int g;
    int ei; int eq; bit eovi; bit eovq;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic set_in(input int a, input bit ob, input int sn, input int cs, input int g);
    adc_data = 12'(a);
    obin     = ob;
    sinw     = 12'(sn);
    cosw     = 12'(cs);
    gain     = 3'(g);
  endtask

  task automatic ce_tick();
    @(negedge clk);
    ce = 1'b1;
    @(posedge clk);
    #1;
    ce = 1'b0;
  endtask

  task automatic idle_clk();
    @(negedge clk);
    ce = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear_ovf = 1'b1;
    @(posedge clk);
    #1;
    clear_ovf = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1000, 0, 0, 2047, 0, 15992, 0, 0, 0};
    vt[1]  = '{1000, 0, 2047, 0, 0, 0, -15992, 0, 0};
    vt[2]  = '{1000, 0, 0, 2047, 1, 31984, 0, 0, 0};
    vt[3]  = '{1000, 0, 0, 2047, 2, 32767, 0, 1, 0};
    vt[4]  = '{-2048, 0, 0, -2048, 0, 32767, 0, 1, 0};
    vt[5]  = '{2048, 1, 2047, 2047, 0, 0, 0, 0, 0};
    vt[6]  = '{4095, 1, 0, 2047, 0, 32736, 0, 0, 0};
    vt[7]  = '{-2048, 0, -2048, 0, 0, 0, -32768, 0, 0};
    vt[8]  = '{-2048, 0, 2047, 0, 0, 0, 32752, 0, 0};
    vt[9]  = '{-1, 0, 64, 65, 0, -1, 1, 0, 0};
    vt[10] = '{1, 0, -3, 1, 7, 1, 3, 0, 0};
    vt[11] = '{2047, 0, 2047, 0, 7, 0, -32768, 0, 1};

    arst_n = 1'b0; ce = 1'b0; clear_ovf = 1'b0;
    set_in(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset i0", int'(i0), 0);
    chk("reset q0", int'(q0), 0);
    chk("reset valid0", int'(v0), 0);
    chk("reset ovf0", int'({oi0, oq0}), 0);
    chk("reset i2/valid2", int'({i2, q2, v2, oi2, oq2}), 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Priming: out_valid from 3rd ce (delay 0) and 5th ce (delay 2).
    set_in(1000, 0, 0, 2047, 0);
    for (int k = 1; k <= 5; k++) begin
      ce_tick();
      chk($sformatf("prime valid0 ce%0d", k), int'(v0), (k >= 3) ? 1 : 0);
      chk($sformatf("prime valid2 ce%0d", k), int'(v2), (k >= 5) ? 1 : 0);
    end
    idle_clk();
    chk("valid0 low between ce", int'(v0), 0);
    chk("i0 holds between ce", int'(i0), 15992);

    // Table vectors on the ADC_DELAY=0 instance, back-to-back ce (full rate).
    for (int n = 0; n < 12; n++) begin
      set_in(vt[n].adc, vt[n].ob, vt[n].sn, vt[n].cs, vt[n].g);
      repeat (3) ce_tick();
      clear_pulse();
      ce_tick();
      chk($sformatf("vec%0d i_out", n), int'(i0), vt[n].ei);
      chk($sformatf("vec%0d q_out", n), int'(q0), vt[n].eq);
      chk($sformatf("vec%0d ovf_i", n), int'(oi0), int'(vt[n].eovi));
      chk($sformatf("vec%0d ovf_q", n), int'(oq0), int'(vt[n].eovq));
      chk($sformatf("vec%0d valid", n), int'(v0), 1);
    end

    // Set and clear in the same cycle: set wins; later clear with clean data.
    set_in(-2048, 0, 0, -2048, 0);
    repeat (3) ce_tick();
    chk("sat ovf_i set", int'(oi0), 1);
    @(negedge clk);
    ce = 1'b1; clear_ovf = 1'b1;
    @(posedge clk);
    #1;
    ce = 1'b0; clear_ovf = 1'b0;
    chk("set beats clear ovf_i", int'(oi0), 1);
    set_in(0, 0, 0, -2048, 0);
    repeat (3) ce_tick();
    chk("ovf_i sticky", int'(oi0), 1);
    chk("i_out clean", int'(i0), 0);
    clear_pulse();
    chk("ovf_i cleared", int'(oi0), 0);

    // Impulse latency, back-to-back then with random idle gaps.
    for (int pass = 0; pass < 2; pass++) begin
      int e2, e0;
      set_in(0, 0, 0, 2047, 0);
      repeat (6) ce_tick();
      e2 = 0; e0 = 0;
      for (int j = 0; j < 10; j++) begin
        int gap;
        gap = (pass == 1) ? int'($urandom_range(0, 3)) : 0;
        for (int m = 0; m < gap; m++) begin
          idle_clk();
          chk($sformatf("p%0d idle hold i2 j%0d", pass, j), int'(i2), e2);
          chk($sformatf("p%0d idle valid2 j%0d", pass, j), int'(v2), 0);
        end
        adc_data = (j == 0) ? 12'(1000) : 12'(0);
        ce_tick();
        e2 = (j == 4) ? 15992 : 0;
        e0 = (j == 2) ? 15992 : 0;
        chk($sformatf("p%0d impulse i2 j%0d", pass, j), int'(i2), e2);
        chk($sformatf("p%0d impulse i0 j%0d", pass, j), int'(i0), e0);
      end
    end

    // Reset mid-stream between ce pulses.
    set_in(1000, 0, 0, 2047, 2);
    repeat (6) ce_tick();
    chk("pre-reset i2", int'(i2), 32767);
    chk("pre-reset ovf_i2", int'(oi2), 1);
    chk("pre-reset valid2", int'(v2), 1);
    idle_clk();
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("mid reset i2", int'(i2), 0);
    chk("mid reset ovf_i2", int'(oi2), 0);
    chk("mid reset i0", int'(i0), 0);
    chk("mid reset valid/ovf0", int'({v0, oi0, oq0}), 0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      ce_tick();
      chk($sformatf("re-prime valid2 ce%0d", k), int'(v2), (k >= 5) ? 1 : 0);
      chk($sformatf("re-prime valid0 ce%0d", k), int'(v0), (k >= 3) ? 1 : 0);
      if (k == 4) chk("re-prime i2 ce4", int'(i2), 0);
    end
    chk("re-prime i2 ce5", int'(i2), 32767);
    chk("re-prime ovf_i2", int'(oi2), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/quadrature_mixer.md
Name: quadrature_mixer

Overview:
Digital downconversion mixer that consumes the signed sine/cosine LO produced by the quarter-wave NCO and one real ADC sample stream. It produces baseband I/Q using I = adc*cos and Q = -adc*sin. The block provides programmable gain, round-half-up, saturation and sticky overflow flags, and feeds the decimation chain. All datapath registers advance only on sample_clk_ce.

Parameters:
DATA_WIDTH, 12, width of ADC sample and of LO sine/cosine (signed)
OUT_WIDTH, 16, width of I/Q outputs (signed); legal range 2..2*DATA_WIDTH-2
ADC_DELAY, 2, extra ADC delay in samples to align with NCO latency; legal range 0..7

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous active-low reset
sample_clk_ce  in  1  sample-rate clock enable; one clk wide per sample
adc_data  in  DATA_WIDTH  ADC sample; two's complement or offset binary
adc_offset_binary  in  1  1: adc_data is offset binary, so MSB is inverted on capture
sinewave  in  DATA_WIDTH  signed LO sine from NCO
cosinewave  in  DATA_WIDTH  signed LO cosine from NCO
gain_shift  in  3  left shift 0..7 applied to products before truncation
clear_ovf  in  1  synchronous clear of sticky overflow flags (not ce-gated)
i_out  out  OUT_WIDTH  signed in-phase result
q_out  out  OUT_WIDTH  signed quadrature result
out_valid  out  1  one-clk pulse when i_out/q_out update with primed pipeline data
ovf_i  out  1  sticky: I path saturated since last clear
ovf_q  out  1  sticky: Q path saturated since last clear

Behaviour:
- Reset (arst_n=0, async): all pipeline registers, the delay line, i_out, q_out, out_valid, ovf_i, ovf_q and the prime counter go to 0.
- Capture stage, on ce: adc_c <= adc_data, with MSB inverted if adc_offset_binary=1. adc_offset_binary is sampled on the same ce.
- Delay line: ADC_DELAY ce-gated registers after adc_c. ADC_DELAY=0 means no extra registers.
- Multiply stage, on ce:
  - p_i <= adc_aligned * cosinewave
  - p_q <= -(adc_aligned * sinewave)
  - Full width P = 2*DATA_WIDTH, signed.
  - Negation is done in P+1 bits, so -2048*2047 cases cannot wrap.
- Output stage, on ce:
  - s = p <<< gain_shift, in P+8 bits; gain_shift is sampled on this ce.
  - r = floor((s + 2^(P-2-OUT_WIDTH)) / 2^(P-1-OUT_WIDTH)), i.e. keep bits [P-2:P-1-OUT_WIDTH] with round-half-up.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and register into i_out/q_out.
- Alignment: the output registered at ce n+1 = f(LO at ce n, adc_data at ce n-1-ADC_DELAY). Latency from adc_data to i_out is ADC_DELAY+3 ce ticks.
- Between ce pulses, every register holds its value.
- Prime counter: saturating count of ce ticks since reset.
  - out_valid=0 until ADC_DELAY+3 ce ticks have occurred.
  - After that, out_valid pulses high for the clk cycle after each ce, coincident with the i_out/q_out update.
- Overflow flags: ovf_i/ovf_q set in the cycle a saturation is registered.
  - clear_ovf=1 clears them on the next clk.
  - Simultaneous set and clear: set wins, flag stays 1.
- Reset mid-stream clears everything, including the prime counter. After release, out_valid restarts only after a full ADC_DELAY+3 ce ticks.
- sample_clk_ce held high continuously is legal: full-rate operation, identical function.

Test Plan:
- ADC_DELAY=0, gain_shift=0, adc=1000 constant, cos=2047, sin=0 -> i_out=15992, q_out=0, out_valid pulses from the 3rd ce onward, no overflow.
- adc=1000, sin=2047, cos=0 -> q_out=-15992, i_out=0. Then gain_shift=1, cos=2047, sin=0 -> i_out=31984. Then gain_shift=2 -> i_out=32767, ovf_i=1, ovf_q=0.
- adc=-2048, cos=-2048 (product 2^22), gain 0 -> i_out=32767, ovf_i=1. Assert clear_ovf on the same cycle a new saturation is registered -> ovf_i stays 1. Then clear with non-saturating data -> ovf_i=0 next clk.
- adc_offset_binary=1, adc_data=12'h800, any LO -> i_out=q_out=0. adc_data=12'hFFF, cos=2047, gain 0 -> i_out=(2047*2047+64)>>7=32736.
- Latency: ADC_DELAY=2, LO cos=2047 constant, single-sample impulse adc=1000 at ce k, 0 otherwise. Requirements:
  - i_out=15992 exactly in the update after ce k+4, and 0 elsewhere.
  - Insert random idle cycles between ce pulses -> identical result sequence.
- Reset mid-stream: after out_valid is active, pulse arst_n low for 1 clk between ce pulses -> all outputs 0 immediately. out_valid returns only after 5 new ce ticks (ADC_DELAY=2).
